sound_env_len_ctrl: RTL and testbench
=====================================

Name: sound_env_len_ctrl

Overview:
- Per-channel sequencing controller for a Game Boy sound channel.
- Produces the `enable` and `target_vol` inputs consumed by the channel mixer stage.
- Sequences the volume envelope from the 64 Hz frame-sequencer tick and the length counter from the 256 Hz tick.
- Restarts both on a channel trigger and disables the channel when length expires.
- One instance per pulse/noise channel. Channel 3 uses `LEN_BITS=8` with the envelope disabled.

Parameters:
- `LEN_BITS`, default 6: width of the length field; the length counter spans 1..2^LEN_BITS.

Ports:
- `clk`  input  1: system clock.
- `rst`  input  1: asynchronous, active-high reset.
- `start`  input  1: single-cycle trigger pulse (NRx4 bit 7 write).
- `len_tick`  input  1: single-cycle 256 Hz frame-sequencer pulse.
- `env_tick`  input  1: single-cycle 64 Hz frame-sequencer pulse.
- `single`  input  1: length enable; 1 means stop the channel at length expiry.
- `length`  input  LEN_BITS: length load field; load value is 2^LEN_BITS - length.
- `initial_vol`  input  4: envelope start volume.
- `env_inc`  input  1: envelope direction; 1 is up, 0 is down.
- `env_sweeps`  input  3: envelope step period in env_ticks; 0 means no envelope stepping.
- `enable`  output  1: channel active (to the mixer).
- `target_vol`  output  4: current envelope volume (to the mixer).
- `len_left`  output  LEN_BITS+1: remaining length count (debug/readback).

Behaviour:
- Reset is asynchronous and active-high. While `rst` is high: `enable`=0, `target_vol`=0, `len_left`=0, `env_cnt`=0, state=OFF. Reset mid-operation aborts everything immediately.
- All outputs are registered.
- Latency: a `start` sampled in cycle N shows its effect on outputs in cycle N+1.
- FSM states: OFF, RUN.
- OFF -> RUN:
  - on `start` when DAC is on, i.e. NOT(`initial_vol`==0 AND `env_inc`==0).
- `start` with DAC off:
  - state stays/goes OFF and `enable`=0.
  - Registers still load as listed below.
- RUN -> OFF:
  - on length expiry, or on a `start` with DAC off.
- Every `start` (from any state) loads:
  - `len_left` = 2^LEN_BITS - `length`, range 1..2^LEN_BITS; a `length` of 0 gives 2^LEN_BITS.
  - `target_vol` = `initial_vol`.
  - `env_cnt` = `env_sweeps`.
- `start` has priority over `len_tick` and `env_tick` in the same cycle; the ticks are ignored that cycle.
- Length counter:
  - Acts on `len_tick` only when state=RUN and `single`=1.
  - If `len_left`==1: `len_left`=0, `enable`=0, state=OFF.
  - Otherwise: `len_left` decrements.
  - `single`=0 freezes the counter; the channel runs indefinitely.
  - No wrap-around: the counter never decrements below 0.
- Envelope:
  - Acts on `env_tick` only when state=RUN and `env_sweeps`!=0.
  - If `env_cnt`<=1: reload `env_cnt`=`env_sweeps`, then step `target_vol` (+1 if `env_inc`, else -1).
  - Otherwise: `env_cnt` decrements.
  - Saturation: up stops at 4'hF, down stops at 4'h0; there is no wrap.
  - `env_sweeps` changed mid-run takes effect at the next reload.
- `len_tick` and `env_tick` in the same cycle are both processed independently.
- If length expires while the envelope steps in the same cycle, `enable`=0 but `target_vol` still updates.
- In OFF, `target_vol` holds its last value; the mixer gates it with `enable`.
- Widths: `len_left` is LEN_BITS+1 bits to hold 2^LEN_BITS. `env_cnt` is 3 bits.

Decomposition:
- Shared sound package:
  - `VOL_MAX` = 4'hF, `VOL_MIN` = 4'h0.
  - `LEN_BITS_PULSE`=6, `LEN_BITS_WAVE`=8.
  - FSM state encoding: OFF=1'b0, RUN=1'b1.
- One natural sub-module: `sound_vol_envelope`.
  - Holds `env_cnt` and the `target_vol` stepper with saturation.
  - Inputs: clk, rst, load, tick, run, initial_vol, env_inc, env_sweeps.
- The length counter and FSM stay in the top module.

Test Plan:
- Length expiry: rst pulse, then `start` with `initial_vol`=8, `env_inc`=0, `env_sweeps`=0, `single`=1, `length`=62 -> `enable`=1, `len_left`=2, `target_vol`=8. After 2 `len_tick`s, `enable`=0 and `len_left`=0.
- Length 0 with `single`=0: `start` with `length`=0 -> `len_left`=64. 100 `len_tick`s leave `len_left`=64 and `enable`=1.
- Envelope up with saturation: `initial_vol`=14, `env_inc`=1, `env_sweeps`=2 -> `target_vol` becomes 15 after the 2nd `env_tick` and stays 15 after 10 more.
- DAC off and down-stepping: `start` with `initial_vol`=0, `env_inc`=0 -> `enable` stays 0. Then `start` with `initial_vol`=1, `env_inc`=0, `env_sweeps`=1 -> `target_vol` goes 1 -> 0 after 1 `env_tick` and holds 0.
- Simultaneous events: `start` asserted in the same cycle as `len_tick` while `len_left`=1 -> channel stays enabled and reloads `len_left`; no expiry.
- Async reset mid-run: `rst` asserted between clock edges during RUN -> `enable`, `target_vol` and `len_left` go to 0 immediately. Releasing `rst` without `start` keeps `enable`=0.

Source files
------------

// File: rtl/sound_env_len_ctrl_pkg.sv
// Purpose: shared sound-channel constants, FSM encoding and volume-step helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sound_env_len_ctrl_pkg;

    // Envelope volume limits (4-bit DAC volume)
    localparam logic [3:0] VOL_MAX = 4'hF;
    localparam logic [3:0] VOL_MIN = 4'h0;

    // Length field widths: pulse/noise channels vs. the wave channel
    localparam int LEN_BITS_PULSE = 6;
    localparam int LEN_BITS_WAVE  = 8;

    // Channel FSM encoding
    localparam logic [0:0] ST_OFF = 1'b0;
    localparam logic [0:0] ST_RUN = 1'b1;

    // One envelope step in the requested direction, clamped at the rails.
    function automatic logic [3:0] vol_step(input logic [3:0] vol, input logic inc);
        logic [3:0] nxt;
        nxt = vol;
        if (inc) begin
            if (vol != VOL_MAX) begin
                nxt = vol + 4'd1;
            end
        end else begin
            if (vol != VOL_MIN) begin
                nxt = vol - 4'd1;
            end
        end
        return nxt;
    endfunction

    // DAC is powered unless the start volume is 0 with a downward envelope.
    function automatic logic dac_is_on(input logic [3:0] initial_vol, input logic env_inc);
        return !((initial_vol == VOL_MIN) && !env_inc);
    endfunction

endpackage

// File: rtl/sound_vol_envelope.sv
// Purpose: volume envelope stepper (sweep period counter + saturating volume).
// Latency: load/tick sampled in cycle N update target_vol in cycle N+1.
// Backpressure: none; load and tick are single-cycle pulses consumed on arrival.
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   load          restart: env_cnt <= env_sweeps, target_vol <= initial_vol
//   tick          64 Hz frame-sequencer pulse
//   run           channel is in RUN; ticks are ignored otherwise
//   initial_vol   volume loaded on restart
//   env_inc       step direction (1 up, 0 down)
//   env_sweeps    step period in ticks; 0 disables stepping
//   target_vol    current envelope volume
module sound_vol_envelope
    import sound_env_len_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       tick,
    input  logic       run,
    input  logic [3:0] initial_vol,
    input  logic       env_inc,
    input  logic [2:0] env_sweeps,
    output logic [3:0] target_vol
);

    logic [2:0] env_cnt;
    logic       step_en;

    // Stepping only happens while running with a non-zero period.
    assign step_en = tick && run && (env_sweeps != 3'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            env_cnt    <= 3'd0;
            target_vol <= VOL_MIN;
        end else if (load) begin
            // Restart wins over a same-cycle tick.
            env_cnt    <= env_sweeps;
            target_vol <= initial_vol;
        end else if (step_en) begin
            if (env_cnt <= 3'd1) begin
                // Reload reads env_sweeps live, so a mid-run period change
                // takes effect here rather than immediately.
                env_cnt    <= env_sweeps;
                target_vol <= vol_step(target_vol, env_inc);
            end else begin
                env_cnt <= env_cnt - 3'd1;
            end
        end
    end

endmodule

// File: rtl/sound_env_len_ctrl.sv
// Purpose: per-channel enable/length/envelope sequencer feeding the mixer.
// Latency: start/len_tick/env_tick sampled in cycle N affect outputs in cycle N+1.
// Backpressure: none; all inputs are single-cycle pulses/levels consumed on arrival.
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   start         trigger pulse (NRx4 bit 7 write)
//   len_tick      256 Hz length-counter pulse
//   env_tick      64 Hz envelope pulse
//   single        length enable; stop channel when length expires
//   length        length load field; counter loads 2^LEN_BITS - length
//   initial_vol   envelope start volume
//   env_inc       envelope direction
//   env_sweeps    envelope period (0 = no stepping)
//   enable        channel active
//   target_vol    current envelope volume
//   len_left      remaining length count
module sound_env_len_ctrl
    import sound_env_len_ctrl_pkg::*;
#(
    parameter int LEN_BITS = LEN_BITS_PULSE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                len_tick,
    input  logic                env_tick,
    input  logic                single,
    input  logic [LEN_BITS-1:0] length,
    input  logic [3:0]          initial_vol,
    input  logic                env_inc,
    input  logic [2:0]          env_sweeps,
    output logic                enable,
    output logic [3:0]          target_vol,
    output logic [LEN_BITS:0]   len_left
);

    localparam logic [LEN_BITS:0] LEN_FULL = {1'b1, {LEN_BITS{1'b0}}};
    localparam logic [LEN_BITS:0] LEN_ONE  = {{LEN_BITS{1'b0}}, 1'b1};
    localparam logic [LEN_BITS:0] LEN_ZERO = '0;

    logic [0:0]        state;
    logic              dac_on;
    logic              running;
    logic [LEN_BITS:0] len_load;

    assign dac_on   = dac_is_on(initial_vol, env_inc);
    assign running  = (state == ST_RUN);
    // length==0 yields the full 2^LEN_BITS count.
    assign len_load = LEN_FULL - {1'b0, length};

    // enable is the state register itself, so it is already registered.
    assign enable = running;

    // FSM and length counter. start takes priority over len_tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_OFF;
            len_left <= LEN_ZERO;
        end else if (start) begin
            len_left <= len_load;
            state    <= dac_on ? ST_RUN : ST_OFF;
        end else if (running && single && len_tick) begin
            if (len_left == LEN_ONE) begin
                len_left <= LEN_ZERO;
                state    <= ST_OFF;
            end else if (len_left != LEN_ZERO) begin
                len_left <= len_left - LEN_ONE;
            end
        end
    end

    // The envelope sees the pre-edge state, so a step still lands in the
    // same cycle that length expiry turns the channel off.
    sound_vol_envelope u_env (
        .clk         (clk),
        .rst         (rst),
        .load        (start),
        .tick        (env_tick),
        .run         (running),
        .initial_vol (initial_vol),
        .env_inc     (env_inc),
        .env_sweeps  (env_sweeps),
        .target_vol  (target_vol)
    );

endmodule

// File: tb/tb_sound_env_len_ctrl.sv
module tb_sound_env_len_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       len_tick;
    logic       env_tick;
    logic       single;
    logic [5:0] length;
    logic [3:0] initial_vol;
    logic       env_inc;
    logic [2:0] env_sweeps;
    logic       enable;
    logic [3:0] target_vol;
    logic [6:0] len_left;

    int n_checks;
    int n_fail;

    sound_env_len_ctrl #(.LEN_BITS(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .len_tick    (len_tick),
        .env_tick    (env_tick),
        .single      (single),
        .length      (length),
        .initial_vol (initial_vol),
        .env_inc     (env_inc),
        .env_sweeps  (env_sweeps),
        .enable      (enable),
        .target_vol  (target_vol),
        .len_left    (len_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change on negedge; the next posedge samples them; outputs are
    // checked at the following negedge.
    task automatic pulse(input logic s, input logic lt, input logic et);
        @(negedge clk);
        start    = s;
        len_tick = lt;
        env_tick = et;
        @(negedge clk);
        start    = 1'b0;
        len_tick = 1'b0;
        env_tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (enable !== 1'b0) begin
            n_fail++; $display("FAIL reset_enable: got %0b want 0", enable);
        end
        n_checks++;
        if (target_vol !== 4'd0) begin
            n_fail++; $display("FAIL reset_vol: got %0d want 0", target_vol);
        end
        n_checks++;
        if (len_left !== 7'd0) begin
            n_fail++; $display("FAIL reset_len: got %0d want 0", len_left);
        end
    endtask

    task automatic test_length_expiry();
        do_reset();
        initial_vol = 4'd8; env_inc = 1'b0; env_sweeps = 3'd0; single = 1'b1; length = 6'd62;
        pulse(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (enable !== 1'b1 || len_left !== 7'd2 || target_vol !== 4'd8) begin
            n_fail++; $display("FAIL len_start: got en=%0b len=%0d vol=%0d want 1/2/8", enable, len_left, target_vol);
        end
        pulse(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (enable !== 1'b1 || len_left !== 7'd1) begin
            n_fail++; $display("FAIL len_tick1: got en=%0b len=%0d want 1/1", enable, len_left);
        end
        pulse(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (enable !== 1'b0 || len_left !== 7'd0) begin
            n_fail++; $display("FAIL len_expire: got en=%0b len=%0d want 0/0", enable, len_left);
        end
        pulse(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (len_left !== 7'd0 || target_vol !== 4'd8) begin
            n_fail++; $display("FAIL len_nowrap: got len=%0d vol=%0d want 0/8", len_left, target_vol);
        end
    endtask

    task automatic test_length_freeze();
        single = 1'b0; length = 6'd0; initial_vol = 4'd8; env_inc = 1'b0; env_sweeps = 3'd0;
        pulse(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (enable !== 1'b1 || len_left !== 7'd64) begin
            n_fail++; $display("FAIL len0_load: got en=%0b len=%0d want 1/64", enable, len_left);
        end
        for (int i = 0; i < 100; i++) pulse(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (enable !== 1'b1 || len_left !== 7'd64) begin
            n_fail++; $display("FAIL len_frozen: got en=%0b len=%0d want 1/64", enable, len_left);
        end
    endtask

    task automatic test_env_up();
        single = 1'b0; length = 6'd0; initial_vol = 4'd14; env_inc = 1'b1; env_sweeps = 3'd2;
        pulse(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (target_vol !== 4'd14) begin
            n_fail++; $display("FAIL env_up_load: got %0d want 14", target_vol);
        end
        pulse(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (target_vol !== 4'd14) begin
            n_fail++; $display("FAIL env_up_tick1: got %0d want 14", target_vol);
        end
        pulse(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (target_vol !== 4'd15) begin
            n_fail++; $display("FAIL env_up_tick2: got %0d want 15", target_vol);
        end
        for (int i = 0; i < 10; i++) pulse(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (target_vol !== 4'd15 || enable !== 1'b1) begin
            n_fail++; $display("FAIL env_up_sat: got vol=%0d en=%0b want 15/1", target_vol, enable);
        end
    endtask

    task automatic test_dac_off_and_down();
        single = 1'b0; length = 6'd0; initial_vol = 4'd0; env_inc = 1'b0; env_sweeps = 3'd3;
        pulse(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (enable !== 1'b0 || target_vol !== 4'd0 || len_left !== 7'd64) begin
            n_fail++; $display("FAIL dac_off: got en=%0b vol=%0d len=%0d want 0/0/64", enable, target_vol, len_left);
        end
        initial_vol = 4'd1; env_sweeps = 3'd1;
        pulse(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (enable !== 1'b1 || target_vol !== 4'd1) begin
            n_fail++; $display("FAIL down_load: got en=%0b vol=%0d want 1/1", enable, target_vol);
        end
        pulse(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (target_vol !== 4'd0) begin
            n_fail++; $display("FAIL down_step: got %0d want 0", target_vol);
        end
        for (int i = 0; i < 3; i++) pulse(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (target_vol !== 4'd0 || enable !== 1'b1) begin
            n_fail++; $display("FAIL down_sat: got vol=%0d en=%0b want 0/1", target_vol, enable);
        end
    endtask

    task automatic test_simultaneous();
        // len_left = 1, volume 5, stepping up every tick
        single = 1'b1; length = 6'd63; initial_vol = 4'd5; env_inc = 1'b1; env_sweeps = 3'd1;
        pulse(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (enable !== 1'b1 || len_left !== 7'd1) begin
            n_fail++; $display("FAIL simul_setup: got en=%0b len=%0d want 1/1", enable, len_left);
        end
        // start beats both ticks: reload to 64-60=4, no expiry, no step
        length = 6'd60;
        pulse(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (enable !== 1'b1 || len_left !== 7'd4 || target_vol !== 4'd5) begin
            n_fail++; $display("FAIL start_priority: got en=%0b len=%0d vol=%0d want 1/4/5", enable, len_left, target_vol);
        end
        // expiry and envelope step in the same cycle
        length = 6'd63;
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (enable !== 1'b0 || len_left !== 7'd0 || target_vol !== 4'd6) begin
            n_fail++; $display("FAIL expire_with_step: got en=%0b len=%0d vol=%0d want 0/0/6", enable, len_left, target_vol);
        end
        // OFF: env ticks no longer step
        pulse(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (target_vol !== 4'd6) begin
            n_fail++; $display("FAIL off_hold_vol: got %0d want 6", target_vol);
        end
    endtask

    task automatic test_async_reset();
        single = 1'b0; length = 6'd10; initial_vol = 4'd7; env_inc = 1'b0; env_sweeps = 3'd0;
        pulse(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (enable !== 1'b1 || len_left !== 7'd54 || target_vol !== 4'd7) begin
            n_fail++; $display("FAIL arst_setup: got en=%0b len=%0d vol=%0d want 1/54/7", enable, len_left, target_vol);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (enable !== 1'b0 || target_vol !== 4'd0 || len_left !== 7'd0) begin
            n_fail++; $display("FAIL arst_immediate: got en=%0b vol=%0d len=%0d want 0/0/0", enable, target_vol, len_left);
        end
        @(negedge clk);
        rst = 1'b0;
        single = 1'b1;
        pulse(1'b0, 1'b1, 1'b1);
        pulse(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (enable !== 1'b0 || len_left !== 7'd0 || target_vol !== 4'd0) begin
            n_fail++; $display("FAIL arst_release: got en=%0b len=%0d vol=%0d want 0/0/0", enable, len_left, target_vol);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        start       = 1'b0;
        len_tick    = 1'b0;
        env_tick    = 1'b0;
        single      = 1'b0;
        length      = 6'd0;
        initial_vol = 4'd0;
        env_inc     = 1'b0;
        env_sweeps  = 3'd0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_length_expiry();
        test_length_freeze();
        test_env_up();
        test_dac_off_and_down();
        test_simultaneous();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
